// File: rtl/code_loader.sv
//==============================================================================
// Module   : code_loader
// Brief    : Serial byte-stream loader that fills code RAM and gates processor reset.
// Revision : 1.0
//==============================================================================
`default_nettype none

module code_loader #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18,
   parameter int MEM_SIZE  = 1024
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 code_we,
   output logic [ADDR_SIZE-1:0] code_addr,
   output logic [WORD_SIZE-1:0] code_din,
   output logic                 processor_reset,
   output logic                 loading,
   output logic                 error
);

   typedef enum logic [1:0] {
      S_HDR   = 2'd0,
      S_DATA  = 2'd1,
      S_RUN   = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t               state_q;
   logic [1:0]           byte_idx_q;
   logic [15:0]          acc_q;
   logic [ADDR_SIZE:0]   count_q;
   logic [ADDR_SIZE:0]   wcnt_q;
   logic                 done_q;
   logic                 code_we_q;
   logic [ADDR_SIZE-1:0] code_addr_q;
   logic [WORD_SIZE-1:0] code_din_q;
   logic                 processor_reset_q;
   logic                 loading_q;
   logic                 error_q;

   // Full little-endian field formed by the two buffered bytes and the current one.
   logic [31:0]          w_field;
   logic                 w_word_bad;
   logic                 w_hdr_bad;
   logic                 w_hdr_big;
   logic [ADDR_SIZE:0]   w_wcnt_inc;

   assign w_field    = {8'd0, rx_data, acc_q};
   assign w_word_bad = |(w_field >> WORD_SIZE);
   assign w_hdr_bad  = |(w_field >> (ADDR_SIZE + 1));
   assign w_hdr_big  = w_field > 32'(MEM_SIZE);
   assign w_wcnt_inc = wcnt_q + 1'b1;

   // done_q marks "image complete": the processor is released one edge later,
   // which for the last word coincides with the RAM commit edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= S_HDR;
         byte_idx_q        <= 2'd0;
         acc_q             <= '0;
         count_q           <= '0;
         wcnt_q            <= '0;
         done_q            <= 1'b0;
         code_we_q         <= 1'b0;
         code_addr_q       <= '0;
         code_din_q        <= '0;
         processor_reset_q <= 1'b1;
         loading_q         <= 1'b0;
         error_q           <= 1'b0;
      end else begin
         code_we_q <= 1'b0;
         if (done_q) begin
            done_q <= 1'b0;
            if (rx_valid) begin
               state_q     <= S_HDR;
               byte_idx_q  <= 2'd1;
               acc_q[7:0]  <= rx_data;
            end else begin
               state_q           <= S_RUN;
               byte_idx_q        <= 2'd0;
               processor_reset_q <= 1'b0;
               loading_q         <= 1'b0;
            end
         end else begin
            case (state_q)
               S_HDR, S_DATA: begin
                  if (rx_valid) begin
                     loading_q <= 1'b1;
                     case (byte_idx_q)
                        2'd0: begin
                           acc_q[7:0] <= rx_data;
                           byte_idx_q <= 2'd1;
                        end
                        2'd1: begin
                           acc_q[15:8] <= rx_data;
                           byte_idx_q  <= 2'd2;
                        end
                        default: begin
                           byte_idx_q <= 2'd0;
                           if (state_q == S_HDR) begin
                              if (w_hdr_bad || w_hdr_big) begin
                                 state_q   <= S_ERROR;
                                 error_q   <= 1'b1;
                                 loading_q <= 1'b0;
                              end else begin
                                 count_q <= w_field[ADDR_SIZE:0];
                                 wcnt_q  <= '0;
                                 if (w_field[ADDR_SIZE:0] == '0) begin
                                    done_q <= 1'b1;
                                 end else begin
                                    state_q <= S_DATA;
                                 end
                              end
                           end else if (w_word_bad) begin
                              state_q   <= S_ERROR;
                              error_q   <= 1'b1;
                              loading_q <= 1'b0;
                           end else begin
                              code_we_q   <= 1'b1;
                              code_addr_q <= wcnt_q[ADDR_SIZE-1:0];
                              code_din_q  <= w_field[WORD_SIZE-1:0];
                              wcnt_q      <= w_wcnt_inc;
                              if (w_wcnt_inc == count_q) begin
                                 done_q <= 1'b1;
                              end
                           end
                        end
                     endcase
                  end
               end
               S_RUN: begin
                  if (rx_valid) begin
                     state_q           <= S_HDR;
                     byte_idx_q        <= 2'd1;
                     acc_q[7:0]        <= rx_data;
                     processor_reset_q <= 1'b1;
                     loading_q         <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign code_we         = code_we_q;
   assign code_addr       = code_addr_q;
   assign code_din        = code_din_q;
   assign processor_reset = processor_reset_q;
   assign loading         = loading_q;
   assign error           = error_q;

endmodule

`default_nettype wire

// File: tb/tb_code_loader.sv
//==============================================================================
// Module   : tb_code_loader
// Brief    : Directed and randomized checks of code_loader against a stream model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_code_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        code_we;
   logic [17:0] code_addr;
   logic [17:0] code_din;
   logic        processor_reset;
   logic        loading;
   logic        error;

   int          vectors = 0;
   int          miscompares = 0;
   int          we_total = 0;
   logic [17:0] obs_addr_q[$];
   logic [17:0] obs_data_q[$];
   logic [17:0] exp_q[$];
   logic [23:0] w;
   int          n;
   int          we_before;

   code_loader #(.ADDR_SIZE(18), .WORD_SIZE(18), .MEM_SIZE(1024)) dut (
      .clock           (clock),
      .reset           (reset),
      .rx_valid        (rx_valid),
      .rx_data         (rx_data),
      .code_we         (code_we),
      .code_addr       (code_addr),
      .code_din        (code_din),
      .processor_reset (processor_reset),
      .loading         (loading),
      .error           (error)
   );

   always #5 clock = ~clock;

   // Record every RAM write seen by the code memory.
   always @(negedge clock) begin
      if (code_we === 1'b1) begin
         obs_addr_q.push_back(code_addr);
         obs_data_q.push_back(code_din);
         we_total++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   // Little-endian 3-byte field, with an optional idle gap before each byte.
   task automatic send_field(input logic [23:0] f, input int max_gap);
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, max_gap)) step();
         send_byte(f[8*i +: 8]);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"},   code_we, 0);
      check({tag, "_addr"}, code_addr, 0);
      check({tag, "_din"},  code_din, 0);
      check({tag, "_prst"}, processor_reset, 1);
      check({tag, "_load"}, loading, 0);
      check({tag, "_err"},  error, 0);
   endtask

   task automatic clear_obs();
      obs_addr_q.delete();
      obs_data_q.delete();
      exp_q.delete();
   endtask

   // Expected image: word k of the stream lands at address k, in order.
   task automatic check_writes(input string tag);
      check({tag, "_nwrites"}, 32'(obs_data_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
         check({tag, "_addr"}, obs_addr_q[i], 32'(i));
         check({tag, "_data"}, obs_data_q[i], exp_q[i]);
      end
   endtask

   // Full load of n random words; checks release timing and the written image.
   task automatic random_load(input string tag, input int cnt, input int max_gap);
      logic [17:0] wd;
      clear_obs();
      send_field(24'(cnt), max_gap);
      for (int k = 0; k < cnt; k++) begin
         wd = 18'($urandom_range(0, 262143));
         exp_q.push_back(wd);
         send_field({6'd0, wd}, max_gap);
      end
      check({tag, "_we_last"}, code_we, 1);
      check({tag, "_prst_hold"}, processor_reset, 1);
      step();
      check({tag, "_prst_rel"}, processor_reset, 0);
      check({tag, "_load_end"}, loading, 0);
      check_writes(tag);
   endtask

   initial begin
      // Reset state
      step();
      reset = 1'b0;
      check_reset_values("rst");

      // N=2 load with fixed words
      clear_obs();
      send_byte(8'h02);
      check("n2_load_on", loading, 1);
      send_byte(8'h00);
      send_byte(8'h00);
      check("n2_we_hdr", code_we, 0);
      send_byte(8'h45);
      send_byte(8'h23);
      send_byte(8'h01);
      check("n2_we0", code_we, 1);
      check("n2_addr0", code_addr, 0);
      check("n2_din0", code_din, 18'h12345);
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'h03);
      check("n2_we1", code_we, 1);
      check("n2_addr1", code_addr, 1);
      check("n2_din1", code_din, 18'h3FFFF);
      check("n2_prst_t", processor_reset, 1);
      check("n2_load_t", loading, 1);
      step();
      check("n2_prst_t1", processor_reset, 0);
      check("n2_load_t1", loading, 0);
      check("n2_we_off", code_we, 0);
      exp_q.push_back(18'h12345);
      exp_q.push_back(18'h3FFFF);
      check_writes("n2");

      // Empty image
      do_reset();
      clear_obs();
      send_byte(8'h00);
      check("n0_load1", loading, 1);
      send_byte(8'h00);
      check("n0_load2", loading, 1);
      send_byte(8'h00);
      check("n0_load3", loading, 1);
      check("n0_prst_t", processor_reset, 1);
      step();
      check("n0_prst_t1", processor_reset, 0);
      check("n0_load_t1", loading, 0);
      step();
      check_writes("n0");

      // Overlong word: bit 18 set
      do_reset();
      clear_obs();
      send_field(24'h000002, 0);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h04);
      check("ovl_err", error, 1);
      check("ovl_prst", processor_reset, 1);
      check("ovl_load", loading, 0);
      for (int i = 0; i < 8; i++) begin
         send_byte(8'($urandom_range(0, 255)));
         check("ovl_err_sticky", error, 1);
         check("ovl_prst_sticky", processor_reset, 1);
      end
      step();
      check_writes("ovl");
      do_reset();
      check_reset_values("ovl_rst");

      // Count too large: N = 1025
      clear_obs();
      send_field(24'h000401, 0);
      check("big_err", error, 1);
      check("big_prst", processor_reset, 1);
      repeat (3) step();
      check_writes("big");

      // Restart from RUN
      do_reset();
      clear_obs();
      send_field(24'h000001, 0);
      send_field(24'h000007, 0);
      step();
      check("rs_run", processor_reset, 0);
      send_byte(8'h01);
      check("rs_prst_up", processor_reset, 1);
      check("rs_load_up", loading, 1);
      send_byte(8'h00);
      send_byte(8'h00);
      send_field(24'h000009, 0);
      check("rs_we", code_we, 1);
      check("rs_addr", code_addr, 0);
      check("rs_din", code_din, 9);
      step();
      check("rs_prst_rel", processor_reset, 0);
      exp_q.push_back(18'h00007);
      exp_q.push_back(18'h00009);
      check("rs_nwr", 32'(obs_data_q.size()), 2);
      check("rs_first", obs_data_q[0], exp_q[0]);
      check("rs_second", obs_data_q[1], exp_q[1]);
      check("rs_second_addr", obs_addr_q[1], 0);

      // Reset after 4 of 6 data bytes
      do_reset();
      send_field(24'h000002, 0);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h01);
      send_byte(8'h44);
      do_reset();
      check_reset_values("mid_rst");
      random_load("mid_fresh", 2, 0);

      // Randomized loads, restarts from RUN with random gaps
      for (int l = 0; l < 6; l++) begin
         random_load("rnd", $urandom_range(1, 8), 3);
         repeat ($urandom_range(0, 4)) step();
      end

      // Largest legal image
      we_before = we_total;
      random_load("max", 1024, 0);
      check("max_we_count", 32'(we_total - we_before), 1024);

      // Random illegal header bit: never writes, always errors
      do_reset();
      clear_obs();
      n = $urandom_range(19, 23);
      w = 24'd1 << n;
      send_field(w, 2);
      check("hdrbit_err", error, 1);
      check("hdrbit_prst", processor_reset, 1);
      step();
      check_writes("hdrbit");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
